// File: rtl/d_ff_pipe_pkg.sv
// rtl/d_ff_pipe_pkg.sv - shared constants and helpers for the elastic register pipeline
// Contents:
//   DEFAULT_WIDTH / DEFAULT_DEPTH  default data width and stage count
//   occ_w(depth)                   width of an occupancy count that reaches depth
package d_ff_pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 3;

  // The count must be able to hold the value DEPTH itself, hence depth+1.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/d_ff_pipe_if.sv
// rtl/d_ff_pipe_if.sv - valid/ready handshake bundle around the elastic pipeline
// Signals:
//   in_valid/in_data/in_ready     upstream side (producer -> pipeline)
//   out_valid/out_data/out_ready  downstream side (pipeline -> consumer)
// Modports:
//   slave   the pipeline itself
//   master  the surrounding producer/consumer environment
interface d_ff_pipe_if
  import d_ff_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/d_ff_stage.sv
// rtl/d_ff_stage.sv - one elastic register stage (valid bit + data word)
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-low reset
//   clr              synchronous flush to the empty/RESET_VAL state
//   up_valid/up_data word offered by the previous stage (or pipeline input)
//   down_ready       the next stage (or consumer) can take this stage's word
//   valid/data       registered contents of this stage
module d_ff_stage
  import d_ff_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // An empty stage always accepts, which is what lets bubbles collapse.
  logic ready;
  assign ready = !valid || down_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (clr) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (ready) begin
      valid <= up_valid;
      // A bubble moving in only clears valid; data keeps its old value.
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/d_ff_pipe.sv
// rtl/d_ff_pipe.sv - WIDTH-bit, DEPTH-stage elastic register pipeline
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-low reset
//   clr        synchronous flush of every stage
//   bus        valid/ready handshake bundle (slave side)
//   occupancy  registered count of valid stages
module d_ff_pipe
  import d_ff_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  d_ff_pipe_if.slave              bus,
  output logic [occ_w(DEPTH)-1:0] occupancy
);

  localparam int OW = occ_w(DEPTH);

  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] down_ready;
  logic             in_xfer;
  logic             out_xfer;

  // Ready ripples from the output back to the input. It is accumulated from
  // the valid bits in one pass so no signal feeds back into itself.
  always_comb begin
    logic acc;
    acc        = bus.out_ready;
    down_ready = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      down_ready[i] = acc;
      acc           = acc || !valid[i];
    end
    bus.in_ready = acc;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (i == 0) begin : g_head
      assign up_valid = bus.in_valid;
      assign up_data  = bus.in_data;
    end else begin : g_body
      assign up_valid = valid[i-1];
      assign up_data  = data[i-1];
    end

    d_ff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .down_ready (down_ready[i]),
      .valid      (valid[i]),
      .data       (data[i])
    );
  end

  assign bus.out_valid = valid[DEPTH-1];
  assign bus.out_data  = data[DEPTH-1];

  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = bus.out_valid && bus.out_ready;

  // Tracks the popcount of valid bits without an adder tree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
    end else if (clr) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + OW'(1);
    end else if (out_xfer && !in_xfer) begin
      occupancy <= occupancy - OW'(1);
    end
  end

endmodule

// File: tb/tb_d_ff_pipe.sv
// tb/tb_d_ff_pipe.sv - self-checking bench for the elastic register pipeline
module tb_d_ff_pipe;
  import d_ff_pipe_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int OW    = occ_w(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic [OW-1:0] occupancy;

  d_ff_pipe_if #(.WIDTH(WIDTH)) bus ();

  d_ff_pipe #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL ('0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Model: ordered list of words in flight, oldest first, each with a slot
  // position 0..DEPTH-1.
  typedef struct {
    logic [WIDTH-1:0] d;
    int               pos;
  } word_t;

  word_t q[$];
  int    total = 0;
  int    bad   = 0;

  logic             s_in_ready;
  logic             s_out_valid;
  logic [WIDTH-1:0] s_out_data;
  logic [OW-1:0]    s_occ;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Advance every word as far as the word ahead allows; the oldest word
  // leaves when it sits in the last slot and the consumer is ready.
  // Returns the new slot of the newest word, or -1 if nothing remains.
  function automatic int moves(input bit ordy, input bit commit);
    int    limit;
    int    p;
    word_t nq[$];
    limit = DEPTH;
    p     = -1;
    for (int k = 0; k < q.size(); k++) begin
      if (k == 0 && q[0].pos == DEPTH - 1 && ordy) continue;
      p     = (q[k].pos + 1 < limit) ? q[k].pos + 1 : q[k].pos;
      limit = p;
      nq.push_back('{q[k].d, p});
    end
    if (commit) q = nq;
    return p;
  endfunction

  task automatic model_edge(input bit iv, input logic [WIDTH-1:0] id, input bit ordy, input bit ic);
    bit acc;
    acc = iv && (moves(ordy, 1'b0) != 0);
    if (ic) begin
      q.delete();
    end else begin
      void'(moves(ordy, 1'b1));
      if (acc) q.push_back('{id, 0});
    end
  endtask

  task automatic compare_model(input bit ordy);
    bit ev;
    ev = (q.size() > 0) && (q[0].pos == DEPTH - 1);
    check("in_ready", 32'(s_in_ready), 32'(moves(ordy, 1'b0) != 0));
    check("out_valid", 32'(s_out_valid), 32'(ev));
    check("occupancy", 32'(s_occ), 32'(q.size()));
    if (ev) check("out_data", 32'(s_out_data), 32'(q[0].d));
  endtask

  // One clock: drive at negedge, sample and compare, then step the model at posedge.
  task automatic cycle(input bit iv, input logic [WIDTH-1:0] id, input bit ordy, input bit ic);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    clr           = ic;
    #1;
    s_in_ready  = bus.in_ready;
    s_out_valid = bus.out_valid;
    s_out_data  = bus.out_data;
    s_occ       = occupancy;
    compare_model(ordy);
    @(posedge clk);
    model_edge(iv, id, ordy, ic);
  endtask

  initial begin
    int thr;

    // Reset with a word presented at the input.
    rst           = 1'b0;
    clr           = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hAA;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_occ", 32'(occupancy), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;

    // First word: latency of DEPTH edges.
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("lat_not_early", 32'(s_out_valid), 0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("lat_valid", 32'(s_out_valid), 1);
    check("lat_data", 32'(s_out_data), 32'hAA);

    // Back-to-back stream, no gaps.
    for (int c = 0; c < 13; c++) begin
      cycle(c < 10, 8'(c + 1), 1'b1, 1'b0);
      if (c >= 3) begin
        check("stream_valid", 32'(s_out_valid), 1);
        check("stream_data", 32'(s_out_data), 32'(c - 2));
      end
    end

    // Fill while stalled, then drain with a simultaneous transfer.
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    check("stall_occ2", 32'(s_occ), 2);
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    check("full_in_ready", 32'(s_in_ready), 0);
    check("full_occ", 32'(s_occ), 3);
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    check("frozen_data", 32'(s_out_data), 32'h11);
    cycle(1'b1, 8'h44, 1'b1, 1'b0);
    check("drain_11", 32'(s_out_data), 32'h11);
    check("both_xfer_rdy", 32'(s_in_ready), 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_22", 32'(s_out_data), 32'h22);
    check("both_xfer_occ", 32'(s_occ), 3);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_33", 32'(s_out_data), 32'h33);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_44", 32'(s_out_data), 32'h44);

    // Bubble collapse behind a stalled word, then clear with a concurrent input.
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h6B, 1'b0, 1'b0);
    check("bubble_occ", 32'(s_occ), 1);
    check("bubble_rdy", 32'(s_in_ready), 1);
    check("bubble_data", 32'(s_out_data), 32'h5A);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("bubble_occ2", 32'(s_occ), 2);
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    check("clr_rdy", 32'(s_in_ready), 1);
    check("clr_pre_occ", 32'(s_occ), 2);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("clr_occ", 32'(s_occ), 0);
    check("clr_valid", 32'(s_out_valid), 0);
    check("clr_data", 32'(s_out_data), 0);
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("clr_dropped", 32'(s_out_valid), 0);
    end

    // Randomized traffic against the model, with varying consumer pressure.
    for (int c = 0; c < 900; c++) begin
      if (c % 150 == 0) thr = $urandom_range(10, 95);
      cycle($urandom_range(0, 3) != 0, 8'($urandom),
            $urandom_range(0, 99) < thr, $urandom_range(0, 39) == 0);
    end

    // Asynchronous reset between edges while full.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'hC1, 1'b0, 1'b0);
    cycle(1'b1, 8'hC2, 1'b0, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 0);
    check("arst_occ", 32'(occupancy), 0);
    check("arst_rdy", 32'(bus.in_ready), 1);
    check("arst_data", 32'(bus.out_data), 0);
    q.delete();
    #1;
    rst = 1'b1;

    for (int c = 0; c < 200; c++) begin
      cycle($urandom_range(0, 1) != 0, 8'($urandom),
            $urandom_range(0, 2) != 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
